// File: rtl/dal_tx_serializer_if.sv
// Byte-in / serial-out bundle for the DAL transmit serializer.
// The source drives the byte handshake; the serializer drives the line and status.
interface dal_tx_serializer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              tx_out;
    logic              tx_busy;
    logic              tx_done;

    modport master (output tx_data, tx_valid, input tx_ready, tx_out, tx_busy, tx_done);
    modport slave  (input tx_data, tx_valid, output tx_ready, tx_out, tx_busy, tx_done);
endinterface

// File: rtl/dal_tx_serializer.sv
// DAL PHY transmit serializer: start bit, DATA_W bits LSB-first, optional even parity,
// STOP_BITS stop bits, each bit held for OVS clocks. Parity is built with DAL_TX_PARITY_EN.
module dal_tx_serializer #(
    parameter int OVS       = 4,
    parameter int DATA_W    = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                clk_i,
    input  logic                reset_ni,
    dal_tx_serializer_if.slave  tx_if
);
    localparam int OW = $clog2(OVS);
    localparam int BW = $clog2(DATA_W);

`ifdef DAL_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

    state_e              state_q, state_d;
    logic [OW-1:0]       ovs_q, ovs_d;
    logic [BW-1:0]       bit_q, bit_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                out_q, out_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ovs_last;
`ifdef DAL_TX_PARITY_EN
    logic                par_q, par_d;
`endif

    assign ovs_last = (ovs_q == OW'(OVS - 1));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            ovs_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            out_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef DAL_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ovs_q   <= ovs_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef DAL_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ovs_d   = ovs_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;
`ifdef DAL_TX_PARITY_EN
        par_d   = par_q;
`endif
        // Every non-idle state spends exactly OVS clocks per bit.
        if (state_q != IDLE)
            ovs_d = ovs_last ? '0 : ovs_q + 1'b1;

        unique case (state_q)
            IDLE: begin
                if (tx_if.tx_valid && ready_q) begin
                    state_d = START;
                    shift_d = tx_if.tx_data;
                    ovs_d   = '0;
                    bit_d   = '0;
`ifdef DAL_TX_PARITY_EN
                    par_d   = ^tx_if.tx_data;
`endif
                end
            end
            START: begin
                if (ovs_last) state_d = DATA;
            end
            DATA: begin
                if (ovs_last) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BW'(DATA_W - 1)) begin
                        bit_d = '0;
`ifdef DAL_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef DAL_TX_PARITY_EN
            PARITY: begin
                if (ovs_last) state_d = STOP;
            end
`endif
            STOP: begin
                if (ovs_last) begin
                    if (bit_q == BW'(STOP_BITS - 1)) begin
                        state_d = IDLE;
                        bit_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they land registered with it.
        unique case (state_d)
            START:   out_d = 1'b0;
            DATA:    out_d = shift_d[0];
`ifdef DAL_TX_PARITY_EN
            PARITY:  out_d = par_d;
`endif
            default: out_d = 1'b1;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    assign tx_if.tx_out   = out_q;
    assign tx_if.tx_ready = ready_q;
    assign tx_if.tx_busy  = busy_q;
    assign tx_if.tx_done  = done_q;
endmodule
